gauss_stats_acc: RTL and testbench

- Downstream consumer of the Box-Muller Gaussian generator output in the BS processor.
- Collects a batch of 2^LOG2_N Gaussian samples after a start pulse.
- Produces running sum, sum of squares and batch mean for on-chip quality checks and Monte Carlo variance estimation.
- Handshake is a start/busy/done control interface; the sample side is a qualified stream.

---
 rtl/gauss_stats_acc.sv | 170 +++++++++++++++++
 tb/tb_gauss_stats_acc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_stats_acc.sv
// Gaussian sample statistics accumulator: collects 2^LOG2_N samples per batch
// and reports the running sum, the sum of squares and the batch mean.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   g_randnum_in[31:0]   Q7.12 sample; only bits [19:0] are used
//   sample_en            g_randnum_in is valid this cycle
//   start, abort         batch control (single-cycle pulses)
//   busy, done           batch in progress / one-cycle results-ready pulse
//   sum_out[31:0]        signed sum of the batch samples (Q.12)
//   sumsq_out[51:0]      unsigned sum of squared samples (Q.24)
//   mean_out[31:0]       sum_out arithmetic-shifted right by LOG2_N
module gauss_stats_acc #(
    parameter int LOG2_N = 10
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] g_randnum_in,
    input  logic        sample_en,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum_out,
    output logic [51:0] sumsq_out,
    output logic [31:0] mean_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                    state_q;
    logic [LOG2_N-1:0]         cnt_q;
    logic                      drain_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      s1_v_q;
    logic signed [19:0]        s1_q;
    logic                      s2_v_q;
    logic signed [19:0]        s2_q;
    logic [39:0]               sq_q;

    logic signed [31:0]        sum_q;
    logic [51:0]               sumsq_q;

    logic [31:0]               sum_out_q;
    logic [51:0]               sumsq_out_q;
    logic [31:0]               mean_out_q;

    logic                      start_ok;
    logic                      abort_ok;
    logic                      cap;
    logic signed [39:0]        s1_ext;
    logic signed [39:0]        sq_d;
    logic signed [31:0]        sum_d;
    logic [51:0]               sumsq_d;
    logic [31:0]               mean_d;

    // Bits [31:20] are pure sign extension and intentionally dropped.
    logic unused_hi;
    assign unused_hi = ^g_randnum_in[31:20];

    always_comb begin
        // busy_q stays high through the done cycle, which blocks a start there.
        start_ok = (state_q == IDLE) && !busy_q && start;
        abort_ok = abort && ((state_q == RUN) || (state_q == DRAIN));
        cap      = (state_q == RUN) && sample_en && !abort_ok;
        s1_ext   = 40'(s1_q);
        sq_d     = s1_ext * s1_ext;
        sum_d    = sum_q + 32'(s2_q);
        sumsq_d  = sumsq_q + {12'd0, sq_q};
        mean_d   = 32'(sum_q >>> LOG2_N);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_q        <= '0;
            s2_v_q      <= 1'b0;
            s2_q        <= '0;
            sq_q        <= '0;
            sum_q       <= '0;
            sumsq_q     <= '0;
            sum_out_q   <= '0;
            sumsq_out_q <= '0;
            mean_out_q  <= '0;
        end else begin
            done_q <= 1'b0;

            s1_v_q <= cap;
            if (cap) begin
                s1_q <= g_randnum_in[19:0];
            end

            s2_v_q <= s1_v_q && !abort_ok;
            s2_q   <= s1_q;
            sq_q   <= 40'(sq_d);

            if (start_ok) begin
                sum_q   <= '0;
                sumsq_q <= '0;
            end else if (s2_v_q) begin
                sum_q   <= sum_d;
                sumsq_q <= sumsq_d;
            end

            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        // Cycle after DONE: done is visible, busy drops next.
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_ok) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (sample_en) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (&cnt_q) begin
                            state_q <= DRAIN;
                            drain_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (abort_ok) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (drain_q) begin
                        state_q <= DONE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    done_q      <= 1'b1;
                    sum_out_q   <= sum_q;
                    sumsq_out_q <= sumsq_q;
                    mean_out_q  <= mean_d;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = sum_out_q;
    assign sumsq_out = sumsq_out_q;
    assign mean_out  = mean_out_q;

endmodule

// File: tb/tb_gauss_stats_acc.sv
// Self-checking bench for gauss_stats_acc with a done-driven scoreboard.
// Batches use LOG2_N=4 (16 samples).
module tb_gauss_stats_acc;

    localparam int LN = 4;
    localparam int NS = 16;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [31:0] g_randnum_in = '0;
    logic        sample_en = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] sum_out;
    logic [51:0] sumsq_out;
    logic [31:0] mean_out;

    always #5 clk = ~clk;

    gauss_stats_acc #(.LOG2_N(LN)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .g_randnum_in (g_randnum_in),
        .sample_en    (sample_en),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .sum_out      (sum_out),
        .sumsq_out    (sumsq_out),
        .mean_out     (mean_out)
    );

    typedef struct {
        logic [31:0] s;
        logic [51:0] q;
        logic [31:0] m;
        int          dc;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        busy_chk = 1'b0;
    logic [31:0] last_s = '0;
    logic [51:0] last_q = '0;
    logic [31:0] last_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy_chk) begin
            chk("busy_after_done", 64'(busy), 64'd0);
            busy_chk = 1'b0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                me = sb.pop_front();
                chk("sum", 64'(sum_out), 64'(me.s));
                chk("sumsq", 64'(sumsq_out), 64'(me.q));
                chk("mean", 64'(mean_out), 64'(me.m));
                chk("done_cycle", 64'(cyc), 64'(me.dc));
                chk("busy_at_done", 64'(busy), 64'd1);
                last_s = me.s;
                last_q = me.q;
                last_m = me.m;
                busy_chk = 1'b1;
            end
        end
    end

    function automatic logic [31:0] samp(input int mode, input int i);
        case (mode)
            0: return 32'h0000_1000;
            1: return (i % 2 == 1) ? 32'hFFFF_F000 : 32'h0000_1000;
            2: return 32'hFFF8_0000;
            3: return 32'h1230_1000;
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after a posedge; returns with the same alignment.
    task automatic run_batch(input int mode, input bit gaps, input int stop,
                             input bit start_in_run, output int dcyc);
        longint      sm = 0;
        longint      sq = 0;
        longint      v;
        logic [19:0] lo;
        logic [31:0] x;
        int          n = 0;
        int          step = 0;
        bit          en;
        exp_t        e;
        dcyc = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n < stop) begin
            en = !(gaps && (step % 3 == 2));
            x = samp(mode, n);
            sample_en = en;
            g_randnum_in = en ? x : 32'hDEAD_BEEF;
            if (start_in_run && n == 5) start = 1'b1;
            if (en) begin
                lo = x[19:0];
                v = longint'($signed(lo));
                sm += v;
                sq += v * v;
                n++;
                if (n == NS) begin
                    e.s = sm[31:0];
                    e.q = sq[51:0];
                    e.m = 32'(sm >>> LN);
                    e.dc = cyc + 4;
                    dcyc = e.dc;
                    sb.push_back(e);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            step++;
        end
        if (stop == NS) begin
            sample_en = 1'b1;
            g_randnum_in = 32'h0007_FFFF;
            repeat (2) begin
                @(posedge clk); #1;
            end
        end
        sample_en = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int d;
        int dc0;
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum_out), 64'd0);
        chk("rst_sumsq", 64'(sumsq_out), 64'd0);
        chk("rst_mean", 64'(mean_out), 64'd0);
        nreset = 1'b1;
        @(posedge clk); #1;

        run_batch(0, 1'b0, NS, 1'b0, d);
        wait_done("basic_done");
        chk("basic_sum_abs", 64'(sum_out), 64'd65536);
        chk("basic_sumsq_abs", 64'(sumsq_out), 64'd268435456);
        chk("basic_mean_abs", 64'(mean_out), 64'd4096);

        run_batch(1, 1'b1, NS, 1'b0, d);
        wait_done("gaps_done");
        chk("gaps_sum_abs", 64'(sum_out), 64'd0);

        run_batch(2, 1'b0, NS, 1'b0, d);
        wait_done("extreme_done");
        chk("extreme_sum_abs", 64'(sum_out), 64'hFF80_0000);
        chk("extreme_sumsq_abs", 64'(sumsq_out), 64'd1 << 42);

        run_batch(3, 1'b0, NS, 1'b0, d);
        wait_done("mask_done");
        chk("mask_sum_abs", 64'(sum_out), 64'd65536);

        dc0 = done_cnt;
        run_batch(4, 1'b0, NS, 1'b1, d);
        k = 0;
        while (cyc < d && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ctrl_done_pulse", 64'(done), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start_in_done", 64'(busy), 64'd0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("ctrl_single_done", 64'(done_cnt), 64'(dc0 + 1));
        chk("ctrl_busy_idle", 64'(busy), 64'd0);
        sb.delete();

        dc0 = done_cnt;
        run_batch(2, 1'b0, 7, 1'b0, d);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("abort_no_done", 64'(done_cnt), 64'(dc0));
        chk("abort_hold_sum", 64'(sum_out), 64'(last_s));
        chk("abort_hold_sumsq", 64'(sumsq_out), 64'(last_q));
        chk("abort_hold_mean", 64'(mean_out), 64'(last_m));

        run_batch(1, 1'b0, NS, 1'b0, d);
        wait_done("fresh_done");

        run_batch(4, 1'b0, 5, 1'b0, d);
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_sum", 64'(sum_out), 64'd0);
        chk("mid_rst_sumsq", 64'(sumsq_out), 64'd0);
        chk("mid_rst_mean", 64'(mean_out), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        last_s = '0;
        last_q = '0;
        last_m = '0;
        @(posedge clk); #1;
        run_batch(0, 1'b0, NS, 1'b0, d);
        wait_done("post_rst_done");
        chk("post_rst_sum_abs", 64'(sum_out), 64'd65536);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
